// File: rtl/lenet5_fmap_streamer_pkg.sv
// ============================================================================
// Module : lenet5_fmap_streamer_pkg
// Brief  : Shared constants, FSM encoding and clog2 helper for the streamer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package lenet5_fmap_streamer_pkg;

    localparam int I_BW1   = 8;
    localparam int I_SIZE1 = 28;

    localparam logic [3:0] c_NO_RESULT = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_STREAM    = 3'd1,
        ST_DRAIN     = 3'd2,
        ST_WAIT_RES  = 3'd3,
        ST_RST_PULSE = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    // Never returns less than 1 so single-entry ranges still get a real bus.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lenet5_fmap_streamer_rd_pipe.sv
// ============================================================================
// Module : lenet5_fmap_streamer_rd_pipe
// Brief  : Aligns a synchronous-RAM read strobe with its data: ce/fmap two
//          cycles after the read.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lenet5_fmap_streamer_rd_pipe #(
    parameter int I_BW = 8
) (
    input  logic            clk,
    input  logic            global_rst,
    input  logic            i_pix_rd,
    input  logic [I_BW-1:0] i_pix_data,
    output logic            o_ce,
    output logic [I_BW-1:0] o_fmap
);

    logic r_rd_d1;

    always_ff @(posedge clk or posedge global_rst) begin
        if (global_rst) begin
            r_rd_d1 <= 1'b0;
            o_ce    <= 1'b0;
            o_fmap  <= '0;
        end else begin
            r_rd_d1 <= i_pix_rd;
            o_ce    <= r_rd_d1;
            // fmap holds its last pixel between bursts
            if (r_rd_d1) begin
                o_fmap <= i_pix_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/lenet5_fmap_streamer.sv
// ============================================================================
// Module : lenet5_fmap_streamer
// Brief  : Streams N_IMG images from pixel RAM into the LeNet-5 core, collects
//          each classification and counts matches against a label RAM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lenet5_fmap_streamer
    import lenet5_fmap_streamer_pkg::*;
#(
    parameter  int I_BW        = I_BW1,
    parameter  int I_SIZE      = I_SIZE1,
    parameter  int N_IMG       = 16,
    parameter  int TIMEOUT     = 65535,
    localparam int PIX_PER_IMG = I_SIZE * I_SIZE,
    localparam int PA_BW       = clog2(N_IMG * PIX_PER_IMG),
    localparam int IA_BW       = clog2(N_IMG)
) (
    input  logic             clk,
    input  logic             global_rst,
    input  logic             i_start,
    output logic [PA_BW-1:0] o_pix_addr,
    output logic             o_pix_rd,
    input  logic [I_BW-1:0]  i_pix_data,
    output logic [IA_BW-1:0] o_lbl_addr,
    input  logic [3:0]       i_lbl_data,
    output logic             o_ce,
    output logic [I_BW-1:0]  o_fmap,
    output logic             o_rst_processEnd,
    input  logic [3:0]       i_class_result,
    input  logic             i_class_en,
    input  logic             i_class_end,
    output logic [3:0]       o_result,
    output logic             o_result_valid,
    output logic [IA_BW:0]   o_correct_cnt,
    output logic             o_timeout_err,
    output logic             o_busy,
    output logic             o_done
);

    localparam int c_PC_BW  = clog2(PIX_PER_IMG);
    localparam int c_TMO_BW = clog2(TIMEOUT);

    localparam logic [c_PC_BW-1:0]  c_PIX_LAST = c_PC_BW'(PIX_PER_IMG - 1);
    localparam logic [c_TMO_BW-1:0] c_TMO_LAST = c_TMO_BW'(TIMEOUT - 1);
    localparam logic [IA_BW-1:0]    c_IMG_LAST = IA_BW'(N_IMG - 1);

    state_t              r_state;
    logic [c_PC_BW-1:0]  r_pix_cnt;
    logic [IA_BW-1:0]    r_img_idx;
    logic                r_drain_cnt;
    logic [c_TMO_BW-1:0] r_tmo_cnt;
    logic                r_got_en;
    logic [3:0]          r_res;
    logic                r_res_bad;

    assign o_lbl_addr = r_img_idx;

    lenet5_fmap_streamer_rd_pipe #(
        .I_BW (I_BW)
    ) u_rd_pipe (
        .clk        (clk),
        .global_rst (global_rst),
        .i_pix_rd   (o_pix_rd),
        .i_pix_data (i_pix_data),
        .o_ce       (o_ce),
        .o_fmap     (o_fmap)
    );

    always_ff @(posedge clk or posedge global_rst) begin
        if (global_rst) begin
            r_state          <= ST_IDLE;
            r_pix_cnt        <= '0;
            r_img_idx        <= '0;
            r_drain_cnt      <= 1'b0;
            r_tmo_cnt        <= '0;
            r_got_en         <= 1'b0;
            r_res            <= '0;
            r_res_bad        <= 1'b0;
            o_pix_addr       <= '0;
            o_pix_rd         <= 1'b0;
            o_rst_processEnd <= 1'b0;
            o_result         <= '0;
            o_result_valid   <= 1'b0;
            o_correct_cnt    <= '0;
            o_timeout_err    <= 1'b0;
            o_busy           <= 1'b0;
            o_done           <= 1'b0;
        end else begin
            o_rst_processEnd <= 1'b0;
            o_result_valid   <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        r_state       <= ST_STREAM;
                        o_pix_rd      <= 1'b1;
                        o_pix_addr    <= '0;
                        r_pix_cnt     <= '0;
                        r_img_idx     <= '0;
                        o_correct_cnt <= '0;
                        o_timeout_err <= 1'b0;
                        o_busy        <= 1'b1;
                        o_done        <= 1'b0;
                    end
                end
                ST_STREAM: begin
                    // Pixel address runs continuously across all images of a run
                    o_pix_addr <= o_pix_addr + PA_BW'(1);
                    r_pix_cnt  <= r_pix_cnt + c_PC_BW'(1);
                    if (r_pix_cnt == c_PIX_LAST) begin
                        o_pix_rd    <= 1'b0;
                        r_pix_cnt   <= '0;
                        r_drain_cnt <= 1'b0;
                        r_state     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    r_drain_cnt <= 1'b1;
                    if (r_drain_cnt) begin
                        r_state   <= ST_WAIT_RES;
                        r_tmo_cnt <= '0;
                        r_got_en  <= 1'b0;
                    end
                end
                ST_WAIT_RES: begin
                    r_tmo_cnt <= r_tmo_cnt + c_TMO_BW'(1);
                    if (i_class_en && !r_got_en) begin
                        r_got_en <= 1'b1;
                        r_res    <= i_class_result;
                    end
                    if (i_class_end) begin
                        r_state          <= ST_RST_PULSE;
                        o_rst_processEnd <= 1'b1;
                        o_result_valid   <= 1'b1;
                        if (r_got_en) begin
                            o_result  <= r_res;
                            r_res_bad <= 1'b0;
                        end else if (i_class_en) begin
                            o_result  <= i_class_result;
                            r_res_bad <= 1'b0;
                        end else begin
                            o_result  <= c_NO_RESULT;
                            r_res_bad <= 1'b1;
                        end
                    end else if (r_tmo_cnt == c_TMO_LAST) begin
                        r_state          <= ST_RST_PULSE;
                        o_rst_processEnd <= 1'b1;
                        o_result_valid   <= 1'b1;
                        o_result         <= c_NO_RESULT;
                        r_res_bad        <= 1'b1;
                        o_timeout_err    <= 1'b1;
                    end
                end
                ST_RST_PULSE: begin
                    // A missing or timed-out result never counts, even against label F
                    if (!r_res_bad && (o_result == i_lbl_data)) begin
                        o_correct_cnt <= o_correct_cnt + (IA_BW + 1)'(1);
                    end
                    if (r_img_idx == c_IMG_LAST) begin
                        r_state <= ST_DONE;
                        o_busy  <= 1'b0;
                        o_done  <= 1'b1;
                    end else begin
                        r_img_idx <= r_img_idx + IA_BW'(1);
                        r_state   <= ST_STREAM;
                        o_pix_rd  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lenet5_fmap_streamer.sv
// ============================================================================
// Module : tb_lenet5_fmap_streamer
// Brief  : Scoreboard bench with RAM and core behavioural models.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lenet5_fmap_streamer;

    localparam int I_BW    = 8;
    localparam int I_SIZE  = 4;
    localparam int N_IMG   = 3;
    localparam int TIMEOUT = 20;
    localparam int PIX     = I_SIZE * I_SIZE;
    localparam int NPIX    = N_IMG * PIX;
    localparam int PA_BW   = 6;   // ceil(log2(48))
    localparam int IA_BW   = 2;   // ceil(log2(3))

    logic             clk = 1'b0;
    logic             global_rst;
    logic             i_start;
    logic [PA_BW-1:0] o_pix_addr;
    logic             o_pix_rd;
    logic [I_BW-1:0]  i_pix_data;
    logic [IA_BW-1:0] o_lbl_addr;
    logic [3:0]       i_lbl_data;
    logic             o_ce;
    logic [I_BW-1:0]  o_fmap;
    logic             o_rst_processEnd;
    logic [3:0]       i_class_result;
    logic             i_class_en;
    logic             i_class_end;
    logic [3:0]       o_result;
    logic             o_result_valid;
    logic [IA_BW:0]   o_correct_cnt;
    logic             o_timeout_err;
    logic             o_busy;
    logic             o_done;

    lenet5_fmap_streamer #(
        .I_BW    (I_BW),
        .I_SIZE  (I_SIZE),
        .N_IMG   (N_IMG),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk              (clk),
        .global_rst       (global_rst),
        .i_start          (i_start),
        .o_pix_addr       (o_pix_addr),
        .o_pix_rd         (o_pix_rd),
        .i_pix_data       (i_pix_data),
        .o_lbl_addr       (o_lbl_addr),
        .i_lbl_data       (i_lbl_data),
        .o_ce             (o_ce),
        .o_fmap           (o_fmap),
        .o_rst_processEnd (o_rst_processEnd),
        .i_class_result   (i_class_result),
        .i_class_en       (i_class_en),
        .i_class_end      (i_class_end),
        .o_result         (o_result),
        .o_result_valid   (o_result_valid),
        .o_correct_cnt    (o_correct_cnt),
        .o_timeout_err    (o_timeout_err),
        .o_busy           (o_busy),
        .o_done           (o_done)
    );

    always #5 clk = ~clk;

    // kind: 0 en then end (later en ignored), 1 en+end together, 2 end only, 3 silent
    typedef struct {
        int         kind;
        logic [3:0] res;
        logic [3:0] res2;
        int         e_at;
        int         d_at;
        bit         spur;
    } resp_t;

    resp_t      modes[$];
    logic [7:0] exp_pix[$];
    logic [3:0] exp_res[$];
    logic [7:0] pix_mem [NPIX];
    logic [3:0] lbl_mem [4];

    int checks   = 0;
    int failures = 0;
    int rd_count;
    int pulse_count;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=absent required=present", name);
    endtask

    always @(posedge clk) begin
        if (o_pix_rd) begin
            i_pix_data <= (int'(o_pix_addr) < NPIX) ? pix_mem[o_pix_addr] : 8'h00;
        end
        i_lbl_data <= lbl_mem[o_lbl_addr];
    end

    // Monitor: pipeline latency, pixel order, pulse alignment, results
    initial begin
        logic [1:0] rd_h;
        rd_h = 2'b00;
        forever begin
            @(negedge clk);
            if (global_rst) begin
                rd_h = 2'b00;
            end else begin
                if (rd_h[1] || o_ce) check("ce_latency", 32'(o_ce), 32'(rd_h[1]));
                rd_h = {rd_h[0], o_pix_rd};
                if (o_pix_rd) rd_count++;
                if (o_ce) begin
                    if (exp_pix.size() == 0) fail_now("fmap_expected");
                    else check("fmap", 32'(o_fmap), 32'(exp_pix.pop_front()));
                end
                if (o_result_valid || o_rst_processEnd) begin
                    pulse_count++;
                    check("pulse_align", 32'(o_rst_processEnd), 32'(o_result_valid));
                    if (o_result_valid) begin
                        if (exp_res.size() == 0) fail_now("result_expected");
                        else check("result", 32'(o_result), 32'(exp_res.pop_front()));
                    end
                end
            end
        end
    end

    // Core model: answers after each complete ce burst
    initial begin
        int    ce_cnt;
        int    w;
        resp_t cur;
        ce_cnt = 0;
        w = -1;
        i_class_en = 1'b0;
        i_class_end = 1'b0;
        i_class_result = 4'h0;
        forever begin
            @(negedge clk);
            i_class_en = 1'b0;
            i_class_end = 1'b0;
            if (global_rst) begin
                ce_cnt = 0;
                w = -1;
            end else if (o_ce) begin
                ce_cnt++;
                if (ce_cnt == PIX) begin
                    ce_cnt = 0;
                    if (modes.size() > 0) begin
                        cur = modes.pop_front();
                        w = 0;
                        if (cur.spur) begin
                            i_class_en = 1'b1;
                            i_class_end = 1'b1;
                            i_class_result = ~cur.res;
                        end
                    end
                end
            end else if (w >= 0) begin
                w++;
                case (cur.kind)
                    0: begin
                        if (w == cur.e_at) begin
                            i_class_en = 1'b1;
                            i_class_result = cur.res;
                        end
                        if (w == cur.d_at) begin
                            i_class_en = 1'b1;
                            i_class_end = 1'b1;
                            i_class_result = cur.res2;
                            w = -1;
                        end
                    end
                    1: if (w == cur.d_at) begin
                        i_class_en = 1'b1;
                        i_class_end = 1'b1;
                        i_class_result = cur.res;
                        w = -1;
                    end
                    2: if (w == cur.d_at) begin
                        i_class_end = 1'b1;
                        i_class_result = cur.res2;
                        w = -1;
                    end
                    default: begin
                        if (o_result_valid) begin
                            check("timeout_latency", 32'(w), 32'(TIMEOUT + 1));
                            w = -1;
                        end else if (w > TIMEOUT + 10) begin
                            fail_now("timeout_result");
                            w = -1;
                        end
                    end
                endcase
            end
        end
    end

    task automatic run(input bit ramp, input int k0, input int k1, input int k2, input bit mid_start);
        int    kinds[3];
        int    exp_cnt;
        bit    exp_err;
        int    bound;
        resp_t r;
        kinds = '{k0, k1, k2};
        exp_cnt = 0;
        exp_err = 1'b0;
        for (int a = 0; a < NPIX; a++) pix_mem[a] = ramp ? 8'(a) : 8'($urandom);
        for (int i = 0; i < 4; i++) lbl_mem[i] = 4'($urandom_range(0, 9));
        for (int a = 0; a < NPIX; a++) exp_pix.push_back(pix_mem[a]);
        for (int i = 0; i < N_IMG; i++) begin
            r.kind = (kinds[i] < 0) ? int'($urandom_range(0, 3)) : kinds[i];
            r.res  = ($urandom_range(0, 1) != 0) ? lbl_mem[i] : 4'($urandom_range(0, 9));
            r.res2 = r.res ^ 4'h5;
            r.e_at = $urandom_range(1, 5);
            r.d_at = (r.kind == 0) ? int'($urandom_range(r.e_at + 1, 12)) : int'($urandom_range(1, 12));
            r.spur = ($urandom_range(0, 1) != 0);
            modes.push_back(r);
            if (r.kind <= 1) begin
                exp_res.push_back(r.res);
                if (r.res == lbl_mem[i]) exp_cnt++;
            end else begin
                exp_res.push_back(4'hF);
                if (r.kind == 3) exp_err = 1'b1;
            end
        end
        rd_count = 0;
        pulse_count = 0;
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check("start_busy", 32'(o_busy), 32'd1);
        check("start_rd", 32'(o_pix_rd), 32'd1);
        check("start_addr", 32'(o_pix_addr), 32'd0);
        check("start_err_clr", 32'(o_timeout_err), 32'd0);
        check("start_cnt_clr", 32'(o_correct_cnt), 32'd0);
        if (mid_start) begin
            repeat (5) @(negedge clk);
            i_start = 1'b1;
            @(negedge clk);
            i_start = 1'b0;
        end
        bound = 0;
        while (!o_done && bound < 1000) begin
            @(negedge clk);
            bound++;
        end
        if (!o_done) fail_now("run_done");
        check("correct_cnt", 32'(o_correct_cnt), 32'(exp_cnt));
        check("timeout_err", 32'(o_timeout_err), 32'(exp_err));
        check("rd_count", 32'(rd_count), 32'(NPIX));
        check("pulse_count", 32'(pulse_count), 32'(N_IMG));
        check("done_busy", 32'(o_busy), 32'd0);
        check("pix_left", 32'(exp_pix.size()), 32'd0);
        check("res_left", 32'(exp_res.size()), 32'd0);
        exp_pix.delete();
        exp_res.delete();
        modes.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int bound;
        int viol;
        global_rst = 1'b1;
        i_start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ce", 32'(o_ce), 32'd0);
        check("rst_rd", 32'(o_pix_rd), 32'd0);
        check("rst_addr", 32'(o_pix_addr), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_fmap", 32'(o_fmap), 32'd0);
        check("rst_valid", 32'(o_result_valid), 32'd0);
        check("rst_pend", 32'(o_rst_processEnd), 32'd0);
        check("rst_cnt", 32'(o_correct_cnt), 32'd0);
        check("rst_err", 32'(o_timeout_err), 32'd0);
        check("rst_result", 32'(o_result), 32'd0);
        check("rst_lbl", 32'(o_lbl_addr), 32'd0);
        global_rst = 1'b0;

        // Reset in the middle of streaming image 0
        for (int a = 0; a < NPIX; a++) pix_mem[a] = 8'(a);
        for (int a = 0; a < NPIX; a++) exp_pix.push_back(pix_mem[a]);
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        bound = 0;
        while (o_pix_addr != 6'd10 && bound < 100) begin
            @(negedge clk);
            bound++;
        end
        if (o_pix_addr != 6'd10) fail_now("reach_pixel_10");
        #1 global_rst = 1'b1;
        #1;
        check("abort_ce", 32'(o_ce), 32'd0);
        check("abort_rd", 32'(o_pix_rd), 32'd0);
        check("abort_addr", 32'(o_pix_addr), 32'd0);
        check("abort_busy", 32'(o_busy), 32'd0);
        check("abort_fmap", 32'(o_fmap), 32'd0);
        @(negedge clk);
        exp_pix.delete();
        modes.delete();
        @(negedge clk);
        global_rst = 1'b0;
        viol = 0;
        repeat (20) begin
            @(negedge clk);
            if (o_ce || o_pix_rd || o_busy) viol++;
        end
        check("post_abort_idle", 32'(viol), 32'd0);

        run(1'b1, 0, 1, 2, 1'b0);
        run(1'b0, 3, -1, -1, 1'b1);
        run(1'b0, 1, 3, 0, 1'b0);
        run(1'b0, 2, 0, 1, 1'b1);
        repeat (4) run(1'b0, -1, -1, -1, ($urandom_range(0, 1) != 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
